// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: word width, access-mode
// codes, arbiter state codes, request payload bundle and size helper.
package dmem_arbiter_pkg;

    localparam int WORD = 32;

    // Access-mode codes as driven on DataMemory's mode input
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    // Arbiter state codes
    localparam logic [1:0] DMA_IDLE   = 2'd0;
    localparam logic [1:0] DMA_ACCESS = 2'd1;
    localparam logic [1:0] DMA_RESP   = 2'd2;

    // One requester's payload
    typedef struct packed {
        logic            we;
        logic [WORD-1:0] addr;
        logic [WORD-1:0] wdata;
        logic [1:0]      mode;
    } dmem_req_t;

    // Number of bytes touched by an access; 0 for an illegal mode code
    function automatic logic [2:0] access_size(input logic [1:0] mode);
        case (mode)
            MEM_BYTE: access_size = 3'd1;
            MEM_HALF: access_size = 3'd2;
            MEM_WORD: access_size = 3'd4;
            default:  access_size = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_align_check.sv
// Combinational legality check for a data-memory access: mode code must be
// legal, the address aligned to the access size, and the last touched byte
// must not exceed mem_limit. Arithmetic carries into bit 32 so an access
// running past 32'hffffffff is rejected instead of wrapping.
module dmem_align_check
    import dmem_arbiter_pkg::*;
(
    input  logic [WORD-1:0] addr,
    input  logic [1:0]      mode,
    input  logic [WORD-1:0] mem_limit,
    output logic            legal
);

    logic [WORD:0] last_byte;
    logic          aligned;

    // Alignment, mode and range evaluation
    always_comb begin
        last_byte = {1'b0, addr} + {{(WORD-2){1'b0}}, access_size(mode)} - {{WORD{1'b0}}, 1'b1};
        case (mode)
            MEM_BYTE: aligned = 1'b1;
            MEM_HALF: aligned = ~addr[0];
            MEM_WORD: aligned = (addr[1:0] == 2'b00);
            default:  aligned = 1'b0;
        endcase
        legal = aligned && !last_byte[WORD] && (last_byte[WORD-1:0] <= mem_limit);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the DataMemory port between the pipeline MEM
// stage (port 0) and the debug/program loader (port 1). Each access runs
// IDLE -> ACCESS -> RESP; rejected accesses skip ACCESS and never strobe
// memory. All outputs are registered.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter logic [31:0] MEM_LIMIT = 32'h000fffff
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [1:0]  mode0,
    input  logic [1:0]  mode1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic [1:0]  memMode,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] memReadData
);

    logic [1:0] state;
    logic       last_grant;
    logic       gnt;
    logic       pick;
    logic       chk_legal;
    dmem_req_t  sel;

    // Round-robin pick and payload mux; ties go to the port not granted last
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else if (req1) begin
            pick = 1'b1;
        end
        if (pick) begin
            sel = '{we: we1, addr: addr1, wdata: wdata1, mode: mode1};
        end else begin
            sel = '{we: we0, addr: addr0, wdata: wdata0, mode: mode0};
        end
    end

    dmem_align_check u_check (
        .addr      (sel.addr),
        .mode      (sel.mode),
        .mem_limit (MEM_LIMIT),
        .legal     (chk_legal)
    );

    // Handshake sequencer and registered memory/requester outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= DMA_IDLE;
            last_grant   <= 1'b1;
            gnt          <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            err          <= 1'b0;
            rdata        <= '0;
            memAddress   <= '0;
            memWriteData <= '0;
            memMode      <= '0;
            memRead      <= 1'b0;
            memWrite     <= 1'b0;
        end else begin
            case (state)
                DMA_IDLE: begin
                    memRead  <= 1'b0;
                    memWrite <= 1'b0;
                    done0    <= 1'b0;
                    done1    <= 1'b0;
                    if (req0 || req1) begin
                        last_grant <= pick;
                        gnt        <= pick;
                        if (chk_legal) begin
                            state        <= DMA_ACCESS;
                            memAddress   <= sel.addr;
                            memWriteData <= sel.wdata;
                            memMode      <= sel.mode;
                            memWrite     <= sel.we;
                            memRead      <= ~sel.we;
                        end else begin
                            // Rejected: answer straight from IDLE, memory untouched
                            state <= DMA_RESP;
                            err   <= 1'b1;
                            rdata <= '0;
                            done0 <= ~pick;
                            done1 <= pick;
                        end
                    end
                end
                DMA_ACCESS: begin
                    state    <= DMA_RESP;
                    memRead  <= 1'b0;
                    memWrite <= 1'b0;
                    err      <= 1'b0;
                    rdata    <= memRead ? memReadData : '0;
                    done0    <= ~gnt;
                    done1    <= gnt;
                end
                DMA_RESP: begin
                    state <= DMA_IDLE;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                end
                default: begin
                    state    <= DMA_IDLE;
                    memRead  <= 1'b0;
                    memWrite <= 1'b0;
                    done0    <= 1'b0;
                    done1    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with a big-endian byte memory model standing in
// for DataMemory. Issued accesses push their expected response into a
// queue; a monitor pops and compares whenever a done pulse appears.
module tb_dmem_arbiter;

    localparam logic [1:0] M_BYTE = 2'b00;
    localparam logic [1:0] M_HALF = 2'b01;
    localparam logic [1:0] M_WORD = 2'b10;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  mode0, mode1;
    logic        done0, done1, err;
    logic [31:0] rdata, memAddress, memWriteData, memReadData;
    logic [1:0]  memMode;
    logic        memRead, memWrite;

    dmem_arbiter #(.MEM_LIMIT(32'h000fffff)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .mode0        (mode0),
        .mode1        (mode1),
        .done0        (done0),
        .done1        (done1),
        .err          (err),
        .rdata        (rdata),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memMode      (memMode),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memReadData  (memReadData)
    );

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
        bit          has_lat;
        int          exp_cyc;
    } sb_t;

    sb_t  exp_q[$];
    sb_t  mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   strobes = 0;

    logic [7:0]  mem [0:4095];
    logic [11:0] ma;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (memRead || memWrite) strobes <= strobes + 1;
    end

    // DataMemory model: commits on negedge, big-endian, combinational read
    always @(negedge clk) begin
        if (memWrite) begin
            case (memMode)
                M_BYTE: mem[memAddress[11:0]] <= memWriteData[7:0];
                M_HALF: begin
                    mem[memAddress[11:0]]         <= memWriteData[15:8];
                    mem[memAddress[11:0] + 12'd1] <= memWriteData[7:0];
                end
                default: begin
                    mem[memAddress[11:0]]         <= memWriteData[31:24];
                    mem[memAddress[11:0] + 12'd1] <= memWriteData[23:16];
                    mem[memAddress[11:0] + 12'd2] <= memWriteData[15:8];
                    mem[memAddress[11:0] + 12'd3] <= memWriteData[7:0];
                end
            endcase
        end
    end

    always_comb begin
        ma = memAddress[11:0];
        case (memMode)
            M_BYTE:  memReadData = {24'h0, mem[ma]};
            M_HALF:  memReadData = {16'h0, mem[ma], mem[ma + 12'd1]};
            default: memReadData = {mem[ma], mem[ma + 12'd1], mem[ma + 12'd2], mem[ma + 12'd3]};
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && (done0 || done1)) begin
            check("done_onehot", {31'b0, done0 & done1}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: done0=%b done1=%b with no access pending", done0, done1);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_port", {31'b0, done1}, {31'b0, mon_e.port});
                check("err", {31'b0, err}, {31'b0, mon_e.err});
                check("rdata", rdata, mon_e.rdata);
                if (mon_e.has_lat) check("latency", cyc, mon_e.exp_cyc);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_done", {30'b0, done1, done0}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_memAddress", memAddress, 32'd0);
        check("rst_memWriteData", memWriteData, 32'd0);
        check("rst_strobes_mode", {28'b0, memMode, memRead, memWrite}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issue one access at a negedge with the arbiter idle; hold until done
    task automatic do_access(input int port, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] mode,
                             input logic exp_err, input logic [31:0] exp_rdata);
        sb_t e;
        int  s0;
        bit  got;
        e.port    = port[0];
        e.err     = exp_err;
        e.rdata   = exp_rdata;
        e.has_lat = 1'b1;
        e.exp_cyc = cyc + (exp_err ? 1 : 2);
        exp_q.push_back(e);
        s0 = strobes;
        if (port == 0) begin
            we0 = we; addr0 = addr; wdata0 = wdata; mode0 = mode; req0 = 1'b1;
        end else begin
            we1 = we; addr1 = addr; wdata1 = wdata; mode1 = mode; req1 = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((port == 0) ? done0 : done1) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL timeout: port %0d addr %h got no done expected done within 20 cycles", port, addr);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check("strobe_cycles", strobes - s0, exp_err ? 32'd0 : 32'd1);
    endtask

    task automatic push_exp(input logic port, input logic [31:0] rd, input bit has_lat, input int exp_cyc);
        sb_t e;
        e.port    = port;
        e.err     = 1'b0;
        e.rdata   = rd;
        e.has_lat = has_lat;
        e.exp_cyc = exp_cyc;
        exp_q.push_back(e);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mode0 = M_WORD; mode1 = M_WORD;
        do_reset();

        // Basic write/read through port 0
        do_access(0, 1'b1, 32'h100, 32'hdeadbeef, M_WORD, 1'b0, 32'h0);
        do_access(0, 1'b0, 32'h100, 32'h0, M_WORD, 1'b0, 32'hdeadbeef);

        // Rejections and range boundaries
        do_access(1, 1'b0, 32'h101, 32'h0, M_HALF, 1'b1, 32'h0);
        do_access(0, 1'b0, 32'h000ffffd, 32'h0, M_WORD, 1'b1, 32'h0);
        do_access(0, 1'b0, 32'h000fffff, 32'h0, M_BYTE, 1'b0, 32'h0);
        do_access(0, 1'b0, 32'h000ffffc, 32'h0, M_WORD, 1'b0, 32'h0);
        do_access(1, 1'b0, 32'h000ffffe, 32'h0, M_HALF, 1'b0, 32'h0);
        do_access(1, 1'b0, 32'h00100000, 32'h0, M_HALF, 1'b1, 32'h0);
        do_access(0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b1, 32'h0);
        do_access(1, 1'b0, 32'hfffffffc, 32'h0, M_WORD, 1'b1, 32'h0);
        do_access(0, 1'b1, 32'h100, 32'h12345678, M_WORD, 1'b0, 32'h0);
        do_access(0, 1'b1, 32'h102, 32'h0, M_WORD, 1'b1, 32'h0);

        // Sub-word accesses, big-endian lanes
        do_access(0, 1'b1, 32'h200, 32'h0000005a, M_BYTE, 1'b0, 32'h0);
        do_access(1, 1'b0, 32'h200, 32'h0, M_HALF, 1'b0, 32'h00005a00);
        do_access(0, 1'b0, 32'h201, 32'h0, M_BYTE, 1'b0, 32'h0);
        do_access(0, 1'b0, 32'h200, 32'h0, M_WORD, 1'b0, 32'h5a000000);
        do_access(1, 1'b1, 32'h400, 32'hcafef00d, M_WORD, 1'b0, 32'h0);
        do_access(0, 1'b0, 32'h400, 32'h0, M_WORD, 1'b0, 32'hcafef00d);
        do_access(0, 1'b0, 32'h402, 32'h0, M_BYTE, 1'b0, 32'h000000f0);
        do_access(1, 1'b1, 32'h406, 32'h0000beef, M_HALF, 1'b0, 32'h0);
        do_access(0, 1'b0, 32'h404, 32'h0, M_WORD, 1'b0, 32'h0000beef);

        // Contention after reset: port 0 first, then strict alternation
        do_reset();
        push_exp(1'b0, 32'h12345678, 1'b1, cyc + 2);
        push_exp(1'b1, 32'h00000000, 1'b0, 0);
        push_exp(1'b0, 32'h12345678, 1'b0, 0);
        push_exp(1'b1, 32'h00000000, 1'b0, 0);
        we0 = 1'b0; addr0 = 32'h100; mode0 = M_WORD;
        we1 = 1'b0; addr1 = 32'h104; mode1 = M_WORD;
        req0 = 1'b1; req1 = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (done0 || done1) n++;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("contention_count", n, 32'd4);
        @(negedge clk);

        // Reset during a write's ACCESS cycle, before its negedge
        we0 = 1'b1; addr0 = 32'h300; wdata0 = 32'h11223344; mode0 = M_WORD; req0 = 1'b1;
        @(posedge clk);
        #1;
        check("access_memWrite", {31'b0, memWrite}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_memWrite_async", {31'b0, memWrite}, 32'd0);
        check("rst_no_done", {30'b0, done1, done0}, 32'd0);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_access(0, 1'b0, 32'h300, 32'h0, M_WORD, 1'b0, 32'h0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
